// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch stage of the 5-stage MIPS pipeline.
// Holds the PC, selects the next PC, runs the instruction-memory request FSM
// and owns the IF/ID pipeline register. A hold buffer keeps a word that
// arrived during a hazard stall. The DRAIN state swallows the reply of a
// request that was abandoned by an ID-stage redirect.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             PC_write,
   input  logic             IF_ID_write,
   input  logic [1:0]       pc_src,
   input  logic [31:0]      branch_tgt,
   input  logic [31:0]      jump_tgt,
   input  logic [31:0]      jr_tgt,
   output logic             imem_req,
   output logic [31:0]      imem_addr,
   input  logic             imem_ready,
   input  logic [31:0]      imem_rdata,
   output logic [31:0]      instr_ID,
   output logic [31:0]      pc4_ID,
   output logic             valid_ID,
   output logic [CNT_W-1:0] bubble_cnt
);

   typedef enum logic [2:0] {
      S_BOOT  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_HOLD  = 3'd3,
      S_DRAIN = 3'd4
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // Redirect target for a non-sequential pc_src; the sequential value is the fallback.
   function automatic logic [31:0] f_sel_target(
      input logic [1:0]  sel,
      input logic [31:0] br,
      input logic [31:0] jt,
      input logic [31:0] jr,
      input logic [31:0] seq
   );
      logic [31:0] res;
      case (sel)
         2'b01:   res = br;
         2'b10:   res = jt;
         2'b11:   res = jr;
         default: res = seq;
      endcase
      return res;
   endfunction

   state_t            r_state;
   logic [31:0]       r_pc;
   logic [31:0]       r_req_addr;
   logic [31:0]       r_hold;

   logic              w_got;
   logic [31:0]       w_word;
   logic              w_redirect;
   logic              w_advance;
   logic              w_drain;
   logic [31:0]       w_pc_plus4;
   logic [31:0]       w_target;
   logic [CNT_W-1:0]  w_cnt_next;

   // Request interface: driven straight from state/PC registers, so it drops with async reset.
   assign imem_req  = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_DRAIN);
   assign imem_addr = (r_state == S_FETCH) ? r_pc : r_req_addr;

   // A word is available when memory answers a live request or the hold buffer is full.
   always_comb begin
      w_got  = 1'b0;
      w_word = imem_rdata;
      case (r_state)
         S_FETCH, S_WAIT: begin
            w_got  = imem_ready;
            w_word = imem_rdata;
         end
         S_HOLD: begin
            w_got  = 1'b1;
            w_word = r_hold;
         end
         default: begin
            w_got  = 1'b0;
            w_word = imem_rdata;
         end
      endcase
   end

   // Redirect/advance decisions and next-PC arithmetic (PC wraps modulo 2^32).
   always_comb begin
      w_pc_plus4 = r_pc + 32'd4;
      w_target   = f_sel_target(pc_src, branch_tgt, jump_tgt, jr_tgt, w_pc_plus4);
      w_redirect = PC_write && (pc_src != 2'b00);
      w_advance  = w_got && PC_write && IF_ID_write;
      if (((r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_DRAIN)) && !imem_ready) begin
         w_drain = 1'b1;
      end else begin
         w_drain = 1'b0;
      end
   end

   // Saturating increment for the bubble counter.
   always_comb begin
      if (bubble_cnt == CNT_MAX) begin
         w_cnt_next = bubble_cnt;
      end else begin
         w_cnt_next = bubble_cnt + CNT_ONE;
      end
   end

   // Fetch FSM, PC, hold buffer and IF/ID register, all updated together.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_BOOT;
         r_pc       <= RESET_PC;
         r_req_addr <= RESET_PC;
         r_hold     <= 32'h0000_0000;
         instr_ID   <= 32'h0000_0000;
         pc4_ID     <= 32'h0000_0000;
         valid_ID   <= 1'b0;
         bubble_cnt <= {CNT_W{1'b0}};
      end else begin
         // The outstanding address tracks the PC on every issue cycle.
         if (r_state == S_FETCH) begin
            r_req_addr <= r_pc;
         end

         if (w_redirect) begin
            // Redirect wins: new PC, flush IF/ID, forget any held word.
            r_pc   <= w_target;
            r_hold <= 32'h0000_0000;
            if (IF_ID_write) begin
               instr_ID   <= 32'h0000_0000;
               pc4_ID     <= 32'h0000_0000;
               valid_ID   <= 1'b0;
               bubble_cnt <= w_cnt_next;
            end
            // An unanswered request must have its reply discarded first.
            if (w_drain) begin
               r_state <= S_DRAIN;
            end else begin
               r_state <= S_FETCH;
            end
         end else if (w_advance) begin
            // Normal delivery into IF/ID, from memory or from the hold buffer.
            instr_ID <= w_word;
            pc4_ID   <= w_pc_plus4;
            valid_ID <= 1'b1;
            r_pc     <= w_pc_plus4;
            r_state  <= S_FETCH;
         end else if (w_got) begin
            // Stalled with a word in hand: park it until the hazard clears.
            if (r_state != S_HOLD) begin
               r_hold <= imem_rdata;
            end
            r_state <= S_HOLD;
         end else begin
            // Nothing to deliver: IF/ID takes a bubble if it may load.
            if (IF_ID_write) begin
               instr_ID   <= 32'h0000_0000;
               pc4_ID     <= 32'h0000_0000;
               valid_ID   <= 1'b0;
               bubble_cnt <= w_cnt_next;
            end
            case (r_state)
               S_BOOT:  r_state <= S_FETCH;
               S_FETCH: r_state <= S_WAIT;
               S_WAIT:  r_state <= S_WAIT;
               S_DRAIN: begin
                  if (imem_ready) begin
                     r_state <= S_FETCH;
                  end else begin
                     r_state <= S_DRAIN;
                  end
               end
               default: r_state <= S_BOOT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage. Words delivered by the bench's imem
// are pushed to a scoreboard as they are driven; a monitor pops and compares
// them whenever IF/ID loads a valid instruction, and checks bubble contents.
module tb_fetch_stage;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst;
   logic             PC_write;
   logic             IF_ID_write;
   logic [1:0]       pc_src;
   logic [31:0]      branch_tgt;
   logic [31:0]      jump_tgt;
   logic [31:0]      jr_tgt;
   logic             imem_req;
   logic [31:0]      imem_addr;
   logic             imem_ready;
   logic [31:0]      imem_rdata;
   logic [31:0]      instr_ID;
   logic [31:0]      pc4_ID;
   logic             valid_ID;
   logic [CNT_W-1:0] bubble_cnt;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc4;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;
   logic last_ifid_w = 1'b0;

   fetch_stage #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .PC_write(PC_write), .IF_ID_write(IF_ID_write),
      .pc_src(pc_src), .branch_tgt(branch_tgt), .jump_tgt(jump_tgt), .jr_tgt(jr_tgt),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready),
      .imem_rdata(imem_rdata), .instr_ID(instr_ID), .pc4_ID(pc4_ID),
      .valid_ID(valid_ID), .bubble_cnt(bubble_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Instruction memory contents: distinct, non-zero word per address.
   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'hC0DE, ~a[15:0]};
   endfunction

   // Remember whether IF/ID was allowed to load on this edge.
   always @(posedge clk) last_ifid_w = IF_ID_write;

   // Scoreboard consumer: every IF/ID load is either the next expected word or a clean bubble.
   always @(negedge clk) begin
      if (last_ifid_w === 1'b1) begin
         if (valid_ID === 1'b1) begin
            exp_t e;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL sb_unexpected: instr_ID=%h pc4_ID=%h, no instruction expected", instr_ID, pc4_ID);
            end else begin
               e = exp_q.pop_front();
               if ({instr_ID, pc4_ID} !== e) begin
                  n_err++;
                  $display("FAIL sb_word: instr_ID=%h pc4_ID=%h, expected %h / %h", instr_ID, pc4_ID, e.instr, e.pc4);
               end
            end
         end else begin
            n_cmp++;
            if ({valid_ID, instr_ID, pc4_ID} !== {1'b0, 32'h0, 32'h0}) begin
               n_err++;
               $display("FAIL sb_bubble: valid=%b instr=%h pc4=%h, expected 0/0/0", valid_ID, instr_ID, pc4_ID);
            end
         end
      end
   end

   // Hard time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic set_defaults();
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
      pc_src      = 2'b00;
      branch_tgt  = 32'h0;
      jump_tgt    = 32'h0;
      jr_tgt      = 32'h0;
      imem_ready  = 1'b0;
      imem_rdata  = 32'h0;
   endtask

   // Leaves the bench on a falling edge with reset just released (DUT in BOOT).
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      set_defaults();
      @(negedge clk);
      exp_q.delete();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      n_cmp++;
      if ({imem_req, valid_ID, instr_ID, pc4_ID, bubble_cnt} !== {1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
         n_err++;
         $display("FAIL reset_state: req=%b valid=%b instr=%h pc4=%h cnt=%h, expected all zero",
                  imem_req, valid_ID, instr_ID, pc4_ID, bubble_cnt);
      end
      rst = 1'b0;
   endtask

   task automatic test_zero_wait();
      do_reset();
      n_cmp++;
      if (imem_req !== 1'b0) begin
         n_err++; $display("FAIL t1_boot_req: imem_req=%b expected 0", imem_req);
      end
      imem_ready = 1'b1;
      imem_rdata = 32'hBAD0_0000;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         n_cmp++;
         if ({imem_req, imem_addr} !== {1'b1, 32'(4 * i)}) begin
            n_err++; $display("FAIL t1_addr: req=%b addr=%h expected 1/%h", imem_req, imem_addr, 32'(4 * i));
         end
         n_cmp++;
         if (valid_ID !== (i != 0)) begin
            n_err++; $display("FAIL t1_valid: valid_ID=%b expected %b at cycle %0d", valid_ID, (i != 0), i);
         end
         imem_rdata = mem_word(32'(4 * i));
         exp_q.push_back({mem_word(32'(4 * i)), 32'(4 * i + 4)});
      end
      @(negedge clk);
      imem_ready = 1'b0;
      n_cmp++;
      if ({valid_ID, pc4_ID, bubble_cnt} !== {1'b1, 32'd16, 4'd1}) begin
         n_err++; $display("FAIL t1_end: valid=%b pc4=%h cnt=%0d expected 1/10/1", valid_ID, pc4_ID, bubble_cnt);
      end
   endtask

   task automatic test_wait_state();
      do_reset();
      imem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         imem_rdata = mem_word(32'(4 * i));
         exp_q.push_back({mem_word(32'(4 * i)), 32'(4 * i + 4)});
      end
      @(negedge clk);
      imem_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         n_cmp++;
         if ({imem_req, imem_addr} !== {1'b1, 32'h8}) begin
            n_err++; $display("FAIL t2_addr_stable: req=%b addr=%h expected 1/00000008", imem_req, imem_addr);
         end
         @(negedge clk);
         n_cmp++;
         if (valid_ID !== 1'b0) begin
            n_err++; $display("FAIL t2_valid_wait: valid_ID=%b expected 0", valid_ID);
         end
      end
      imem_ready = 1'b1;
      imem_rdata = mem_word(32'h8);
      exp_q.push_back({mem_word(32'h8), 32'd12});
      @(negedge clk);
      imem_ready = 1'b0;
      n_cmp++;
      if ({valid_ID, pc4_ID, bubble_cnt, imem_addr} !== {1'b1, 32'd12, 4'd4, 32'd12}) begin
         n_err++; $display("FAIL t2_end: valid=%b pc4=%h cnt=%0d addr=%h expected 1/c/4/c",
                           valid_ID, pc4_ID, bubble_cnt, imem_addr);
      end
   endtask

   task automatic test_hold();
      do_reset();
      imem_ready = 1'b1;
      @(negedge clk);
      imem_rdata = mem_word(32'h0);
      exp_q.push_back({mem_word(32'h0), 32'd4});
      @(negedge clk);
      imem_rdata = mem_word(32'h4);
      exp_q.push_back({mem_word(32'h4), 32'd8});
      PC_write    = 1'b0;
      IF_ID_write = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         n_cmp++;
         if ({imem_req, valid_ID, instr_ID, pc4_ID} !== {1'b0, 1'b1, mem_word(32'h0), 32'd4}) begin
            n_err++; $display("FAIL t3_hold_frozen: req=%b valid=%b instr=%h pc4=%h expected 0/1/%h/4",
                              imem_req, valid_ID, instr_ID, pc4_ID, mem_word(32'h0));
         end
         imem_rdata = 32'hDEAD_BEEF;
      end
      PC_write    = 1'b1;
      IF_ID_write = 1'b1;
      @(negedge clk);
      imem_ready = 1'b0;
      n_cmp++;
      if ({valid_ID, instr_ID, pc4_ID, imem_addr} !== {1'b1, mem_word(32'h4), 32'd8, 32'd8}) begin
         n_err++; $display("FAIL t3_release: valid=%b instr=%h pc4=%h addr=%h expected 1/%h/8/8",
                           valid_ID, instr_ID, pc4_ID, imem_addr, mem_word(32'h4));
      end
   endtask

   task automatic test_redirect_drain();
      do_reset();
      imem_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         imem_rdata = mem_word(32'(4 * i));
         exp_q.push_back({mem_word(32'(4 * i)), 32'(4 * i + 4)});
      end
      @(negedge clk);
      imem_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({imem_req, imem_addr} !== {1'b1, 32'h10}) begin
         n_err++; $display("FAIL t4_wait_addr: req=%b addr=%h expected 1/00000010", imem_req, imem_addr);
      end
      pc_src     = 2'b01;
      branch_tgt = 32'h40;
      @(negedge clk);
      n_cmp++;
      if ({imem_req, imem_addr, valid_ID} !== {1'b1, 32'h10, 1'b0}) begin
         n_err++; $display("FAIL t4_drain: req=%b addr=%h valid=%b expected 1/00000010/0", imem_req, imem_addr, valid_ID);
      end
      pc_src     = 2'b00;
      imem_ready = 1'b1;
      imem_rdata = mem_word(32'h10);
      @(negedge clk);
      n_cmp++;
      if ({imem_req, imem_addr, valid_ID} !== {1'b1, 32'h40, 1'b0}) begin
         n_err++; $display("FAIL t4_new_addr: req=%b addr=%h valid=%b expected 1/00000040/0", imem_req, imem_addr, valid_ID);
      end
      imem_rdata = mem_word(32'h40);
      exp_q.push_back({mem_word(32'h40), 32'h44});
      @(negedge clk);
      imem_ready = 1'b0;
      n_cmp++;
      if ({valid_ID, pc4_ID, bubble_cnt} !== {1'b1, 32'h44, 4'd4}) begin
         n_err++; $display("FAIL t4_end: valid=%b pc4=%h cnt=%0d expected 1/44/4", valid_ID, pc4_ID, bubble_cnt);
      end
   endtask

   task automatic test_jump();
      do_reset();
      imem_ready = 1'b1;
      @(negedge clk);
      imem_rdata = mem_word(32'h0);
      exp_q.push_back({mem_word(32'h0), 32'd4});
      @(negedge clk);
      PC_write   = 1'b0;
      pc_src     = 2'b10;
      jump_tgt   = 32'h100;
      imem_ready = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({imem_addr, valid_ID} !== {32'h4, 1'b0}) begin
         n_err++; $display("FAIL t5_no_jump: addr=%h valid=%b expected 00000004/0", imem_addr, valid_ID);
      end
      PC_write   = 1'b1;
      pc_src     = 2'b00;
      imem_ready = 1'b1;
      imem_rdata = mem_word(32'h4);
      exp_q.push_back({mem_word(32'h4), 32'd8});
      @(negedge clk);
      n_cmp++;
      if ({imem_addr, valid_ID, pc4_ID} !== {32'h8, 1'b1, 32'h8}) begin
         n_err++; $display("FAIL t5_pc_kept: addr=%h valid=%b pc4=%h expected 8/1/8", imem_addr, valid_ID, pc4_ID);
      end
      pc_src     = 2'b10;
      imem_rdata = mem_word(32'h8);
      @(negedge clk);
      n_cmp++;
      if ({imem_addr, valid_ID, instr_ID} !== {32'h100, 1'b0, 32'h0}) begin
         n_err++; $display("FAIL t5_jump: addr=%h valid=%b instr=%h expected 00000100/0/0", imem_addr, valid_ID, instr_ID);
      end
      pc_src     = 2'b00;
      imem_rdata = mem_word(32'h100);
      exp_q.push_back({mem_word(32'h100), 32'h104});
      @(negedge clk);
      imem_ready = 1'b0;
      n_cmp++;
      if ({valid_ID, pc4_ID, bubble_cnt} !== {1'b1, 32'h104, 4'd3}) begin
         n_err++; $display("FAIL t5_end: valid=%b pc4=%h cnt=%0d expected 1/104/3", valid_ID, pc4_ID, bubble_cnt);
      end
   endtask

   task automatic test_pc_wrap();
      do_reset();
      imem_ready = 1'b1;
      @(negedge clk);
      pc_src     = 2'b10;
      jump_tgt   = 32'hFFFF_FFFC;
      imem_rdata = mem_word(32'h0);
      @(negedge clk);
      n_cmp++;
      if (imem_addr !== 32'hFFFF_FFFC) begin
         n_err++; $display("FAIL wrap_addr: addr=%h expected fffffffc", imem_addr);
      end
      pc_src     = 2'b00;
      imem_rdata = mem_word(32'hFFFF_FFFC);
      exp_q.push_back({mem_word(32'hFFFF_FFFC), 32'h0});
      @(negedge clk);
      imem_ready = 1'b0;
      n_cmp++;
      if ({imem_addr, valid_ID, pc4_ID} !== {32'h0, 1'b1, 32'h0}) begin
         n_err++; $display("FAIL wrap_pc: addr=%h valid=%b pc4=%h expected 0/1/0", imem_addr, valid_ID, pc4_ID);
      end
   endtask

   task automatic test_reset_mid_wait();
      do_reset();
      imem_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         imem_rdata = mem_word(32'(4 * i));
         exp_q.push_back({mem_word(32'(4 * i)), 32'(4 * i + 4)});
      end
      @(negedge clk);
      imem_ready  = 1'b0;
      IF_ID_write = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({imem_req, imem_addr, valid_ID, pc4_ID} !== {1'b1, 32'h8, 1'b1, 32'h8}) begin
         n_err++; $display("FAIL t6_pre: req=%b addr=%h valid=%b pc4=%h expected 1/8/1/8",
                           imem_req, imem_addr, valid_ID, pc4_ID);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if ({imem_req, valid_ID, instr_ID, pc4_ID, bubble_cnt} !== {1'b0, 1'b0, 32'h0, 32'h0, 4'h0}) begin
         n_err++; $display("FAIL t6_async: req=%b valid=%b instr=%h pc4=%h cnt=%h expected all zero",
                           imem_req, valid_ID, instr_ID, pc4_ID, bubble_cnt);
      end
      @(negedge clk);
      IF_ID_write = 1'b1;
      imem_ready  = 1'b1;
      imem_rdata  = mem_word(32'h8);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_cmp++;
      if ({imem_addr, valid_ID, bubble_cnt} !== {32'h0, 1'b0, 4'd1}) begin
         n_err++; $display("FAIL t6_restart: addr=%h valid=%b cnt=%0d expected 0/0/1", imem_addr, valid_ID, bubble_cnt);
      end
      imem_rdata = mem_word(32'h0);
      exp_q.push_back({mem_word(32'h0), 32'd4});
      @(negedge clk);
      imem_ready = 1'b0;
      n_cmp++;
      if ({valid_ID, pc4_ID} !== {1'b1, 32'd4}) begin
         n_err++; $display("FAIL t6_first: valid=%b pc4=%h expected 1/4", valid_ID, pc4_ID);
      end
   endtask

   task automatic test_bubble_saturation();
      do_reset();
      repeat (10) @(negedge clk);
      n_cmp++;
      if (bubble_cnt !== 4'd10) begin
         n_err++; $display("FAIL sat_mid: bubble_cnt=%0d expected 10", bubble_cnt);
      end
      repeat (10) @(negedge clk);
      n_cmp++;
      if (bubble_cnt !== 4'hF) begin
         n_err++; $display("FAIL sat_top: bubble_cnt=%0d expected 15", bubble_cnt);
      end
   endtask

   initial begin
      rst = 1'b1;
      set_defaults();
      test_reset();
      test_zero_wait();
      test_wait_state();
      test_hold();
      test_redirect_drain();
      test_jump();
      test_pc_wrap();
      test_reset_mid_wait();
      test_bubble_saturation();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++; $display("FAIL sb_leftover: %0d expected words never delivered, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
